// File: rtl/frame_sequencer.sv
// Frame sequencer: streams one frame of pixels into a frame RAM (FILL), then
// reads it back in raster order (SCAN) with a one-cycle qualify tail (DRAIN).
module frame_sequencer #(
    parameter int H_RES = 640,
    parameter int V_RES = 480
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        loop,
    input  logic        wr_valid,
    input  logic [14:0] wr_data,
    output logic        wr_ready,
    output logic        ram_we,
    output logic [19:0] ram_wr_addr,
    output logic [14:0] ram_din,
    output logic        ram_re,
    output logic [19:0] ram_rd_addr,
    output logic        pix_valid,
    output logic [9:0]  X,
    output logic [9:0]  Y,
    output logic        busy,
    output logic        frame_done
);

    typedef enum logic [1:0] {IDLE, FILL, SCAN, DRAIN} state_t;

    localparam logic [9:0] X_LAST = 10'(H_RES - 1);
    localparam logic [9:0] Y_LAST = 10'(V_RES - 1);

    state_t     state_reg;
    logic [9:0] wx_reg, wy_reg, rx_reg, ry_reg;
    // Set after the final accepted write so SCAN waits for its RAM strobe.
    logic       fill_done_reg;
    logic       accept, wr_last, rd_last;

    assign wr_ready    = (state_reg == FILL) && !fill_done_reg;
    assign accept      = wr_valid && wr_ready;
    assign wr_last     = (wx_reg == X_LAST) && (wy_reg == Y_LAST);
    assign rd_last     = (rx_reg == X_LAST) && (ry_reg == Y_LAST);
    assign ram_re      = (state_reg == SCAN);
    assign ram_rd_addr = {ry_reg, rx_reg};
    assign busy        = (state_reg != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            wx_reg        <= '0;
            wy_reg        <= '0;
            rx_reg        <= '0;
            ry_reg        <= '0;
            fill_done_reg <= 1'b0;
            ram_we        <= 1'b0;
            ram_wr_addr   <= '0;
            ram_din       <= '0;
            pix_valid     <= 1'b0;
            X             <= '0;
            Y             <= '0;
            frame_done    <= 1'b0;
        end else begin
            ram_we     <= accept;
            pix_valid  <= ram_re;
            X          <= rx_reg;
            Y          <= ry_reg;
            frame_done <= ram_re && rd_last;

            if (accept) begin
                ram_wr_addr <= {wy_reg, wx_reg};
                ram_din     <= wr_data;
                if (wx_reg == X_LAST) begin
                    wx_reg <= '0;
                    wy_reg <= (wy_reg == Y_LAST) ? 10'd0 : wy_reg + 10'd1;
                end else begin
                    wx_reg <= wx_reg + 10'd1;
                end
            end

            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg     <= FILL;
                        wx_reg        <= '0;
                        wy_reg        <= '0;
                        fill_done_reg <= 1'b0;
                    end
                end
                FILL: begin
                    if (accept && wr_last) begin
                        fill_done_reg <= 1'b1;
                    end else if (fill_done_reg) begin
                        state_reg     <= SCAN;
                        rx_reg        <= '0;
                        ry_reg        <= '0;
                        fill_done_reg <= 1'b0;
                    end
                end
                SCAN: begin
                    // Counters hold on the last pixel so X/Y stay meaningful in DRAIN.
                    if (rd_last) begin
                        state_reg <= DRAIN;
                    end else if (rx_reg == X_LAST) begin
                        rx_reg <= '0;
                        ry_reg <= ry_reg + 10'd1;
                    end else begin
                        rx_reg <= rx_reg + 10'd1;
                    end
                end
                DRAIN: begin
                    if (loop) begin
                        state_reg     <= FILL;
                        wx_reg        <= '0;
                        wy_reg        <= '0;
                        fill_done_reg <= 1'b0;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer: a 4x2 instance for the main flows and a
// 1x1 instance for the degenerate frame size.
module tb_frame_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0, loop = 1'b0, wr_valid = 1'b0;
    logic [14:0] wr_data = '0;
    logic        wr_ready, ram_we, ram_re, pix_valid, busy, frame_done;
    logic [19:0] ram_wr_addr, ram_rd_addr;
    logic [14:0] ram_din;
    logic [9:0]  X, Y;

    logic        start1 = 1'b0, wr_valid1 = 1'b0;
    logic [14:0] wr_data1 = '0;
    logic        wr_ready1, ram_we1, ram_re1, pix_valid1, busy1, frame_done1;
    logic [19:0] ram_wr_addr1, ram_rd_addr1;
    logic [14:0] ram_din1;
    logic [9:0]  x1, y1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    frame_sequencer #(.H_RES(4), .V_RES(2)) dut (
        .clk(clk), .rst(rst), .start(start), .loop(loop),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .ram_we(ram_we), .ram_wr_addr(ram_wr_addr), .ram_din(ram_din),
        .ram_re(ram_re), .ram_rd_addr(ram_rd_addr), .pix_valid(pix_valid),
        .X(X), .Y(Y), .busy(busy), .frame_done(frame_done)
    );

    frame_sequencer #(.H_RES(1), .V_RES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .loop(1'b0),
        .wr_valid(wr_valid1), .wr_data(wr_data1), .wr_ready(wr_ready1),
        .ram_we(ram_we1), .ram_wr_addr(ram_wr_addr1), .ram_din(ram_din1),
        .ram_re(ram_re1), .ram_rd_addr(ram_rd_addr1), .pix_valid(pix_valid1),
        .X(x1), .Y(y1), .busy(busy1), .frame_done(frame_done1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " wr_ready"}, 32'(wr_ready), 0);
        chk({tag, " ram_we"}, 32'(ram_we), 0);
        chk({tag, " ram_wr_addr"}, 32'(ram_wr_addr), 0);
        chk({tag, " ram_din"}, 32'(ram_din), 0);
        chk({tag, " ram_re"}, 32'(ram_re), 0);
        chk({tag, " ram_rd_addr"}, 32'(ram_rd_addr), 0);
        chk({tag, " pix_valid"}, 32'(pix_valid), 0);
        chk({tag, " X"}, 32'(X), 0);
        chk({tag, " Y"}, 32'(Y), 0);
        chk({tag, " busy"}, 32'(busy), 0);
        chk({tag, " frame_done"}, 32'(frame_done), 0);
    endtask

    initial begin
        // Reset state
        step;
        step;
        chk_all_zero("reset");
        rst = 1'b1;
        step;
        chk("idle busy", 32'(busy), 0);

        // Full frame, continuous data 0..7
        start = 1'b1;
        step;
        start = 1'b0;
        chk("fill busy", 32'(busy), 1);
        chk("fill wr_ready", 32'(wr_ready), 1);
        wr_valid = 1'b1;
        wr_data  = 15'd0;
        for (int i = 0; i < 8; i++) begin
            step;
            $display("[TB] write %0d addr 0x%05h data 0x%0h", i, ram_wr_addr, ram_din);
            chk("w1 ram_we", 32'(ram_we), 1);
            chk("w1 addr", 32'(ram_wr_addr), 32'(((i / 4) << 10) | (i % 4)));
            chk("w1 din", 32'(ram_din), 32'(i));
            chk("w1 ram_re", 32'(ram_re), 0);
            chk("w1 wr_ready", 32'(wr_ready), 32'(i != 7));
            wr_data = 15'(i + 1);
            if (i == 7) wr_valid = 1'b0;
        end
        for (int j = 0; j < 8; j++) begin
            start = (j == 3);
            step;
            $display("[TB] read %0d addr 0x%05h pix_valid %0d", j, ram_rd_addr, pix_valid);
            chk("r1 ram_re", 32'(ram_re), 1);
            chk("r1 ram_we", 32'(ram_we), 0);
            chk("r1 addr", 32'(ram_rd_addr), 32'(((j / 4) << 10) | (j % 4)));
            chk("r1 frame_done", 32'(frame_done), 0);
            chk("r1 pix_valid", 32'(pix_valid), 32'(j > 0));
            if (j > 0) begin
                chk("r1 X", 32'(X), 32'((j - 1) % 4));
                chk("r1 Y", 32'(Y), 32'((j - 1) / 4));
            end
        end
        start = 1'b0;
        step;
        chk("drain ram_re", 32'(ram_re), 0);
        chk("drain pix_valid", 32'(pix_valid), 1);
        chk("drain X", 32'(X), 3);
        chk("drain Y", 32'(Y), 1);
        chk("drain frame_done", 32'(frame_done), 1);
        chk("drain busy", 32'(busy), 1);
        step;
        chk("post busy", 32'(busy), 0);
        chk("post frame_done", 32'(frame_done), 0);
        chk("post pix_valid", 32'(pix_valid), 0);
        step;
        chk("start ignored busy", 32'(busy), 0);

        // Toggled wr_valid, then loop back into FILL
        start = 1'b1;
        step;
        start = 1'b0;
        for (int c = 0; c < 16; c++) begin
            wr_valid = (c % 2 == 0);
            wr_data  = 15'(16'h40 + c / 2);
            step;
            chk("w2 ram_we", 32'(ram_we), 32'(c % 2 == 0));
            if (c % 2 == 0) begin
                $display("[TB] write %0d addr 0x%05h data 0x%0h", c / 2, ram_wr_addr, ram_din);
                chk("w2 addr", 32'(ram_wr_addr), 32'((((c / 2) / 4) << 10) | ((c / 2) % 4)));
                chk("w2 din", 32'(ram_din), 32'(16'h40 + c / 2));
            end
        end
        wr_valid = 1'b0;
        chk("w2 scan start", 32'(ram_re), 1);
        chk("w2 scan addr0", 32'(ram_rd_addr), 0);
        loop = 1'b1;
        for (int j = 1; j < 8; j++) begin
            step;
            chk("r2 addr", 32'(ram_rd_addr), 32'(((j / 4) << 10) | (j % 4)));
        end
        step;
        chk("r2 frame_done", 32'(frame_done), 1);
        step;
        chk("loop wr_ready", 32'(wr_ready), 1);
        chk("loop busy", 32'(busy), 1);
        chk("loop ram_re", 32'(ram_re), 0);
        loop     = 1'b0;
        wr_valid = 1'b1;
        wr_data  = 15'h55;
        step;
        chk("loop ram_we", 32'(ram_we), 1);
        chk("loop addr", 32'(ram_wr_addr), 0);
        chk("loop din", 32'(ram_din), 32'h55);
        wr_data = 15'h66;
        step;
        chk("loop addr1", 32'(ram_wr_addr), 1);

        // Asynchronous reset in the middle of FILL
        #2 rst = 1'b0;
        #1;
        chk_all_zero("async rst");
        #2 rst = 1'b1;
        step;
        chk("after rst busy", 32'(busy), 0);
        chk("after rst ram_we", 32'(ram_we), 0);
        chk("after rst wr_ready", 32'(wr_ready), 0);
        step;
        chk("after rst idle", 32'(busy), 0);
        wr_valid = 1'b0;

        // 1x1 frame
        start1 = 1'b1;
        step;
        start1    = 1'b0;
        chk("1x1 wr_ready", 32'(wr_ready1), 1);
        wr_valid1 = 1'b1;
        wr_data1  = 15'h1234;
        step;
        wr_valid1 = 1'b0;
        chk("1x1 ram_we", 32'(ram_we1), 1);
        chk("1x1 waddr", 32'(ram_wr_addr1), 0);
        chk("1x1 din", 32'(ram_din1), 32'h1234);
        step;
        chk("1x1 ram_re", 32'(ram_re1), 1);
        chk("1x1 ram_we off", 32'(ram_we1), 0);
        step;
        chk("1x1 drain ram_re", 32'(ram_re1), 0);
        chk("1x1 pix_valid", 32'(pix_valid1), 1);
        chk("1x1 frame_done", 32'(frame_done1), 1);
        chk("1x1 drain busy", 32'(busy1), 1);
        step;
        chk("1x1 idle", 32'(busy1), 0);
        chk("1x1 frame_done off", 32'(frame_done1), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/frame_sequencer.md
FRAME_SEQUENCER -- requirements
Module: frame_sequencer

Interface
REQ-001 Parameter H_RES, default 640: pixels per line; legal range 1..1024.
REQ-002 Parameter V_RES, default 480: lines per frame; legal range 1..1024.
REQ-003 clk  input  1: single clock; all state changes on its rising edge.
REQ-004 rst  input  1: reset, asynchronous assert, active-low (0 = reset).
REQ-005 start  input  1: one-cycle request to run one frame (FILL then SCAN).
REQ-006 loop  input  1: sampled at end of SCAN; when 1, the block re-enters FILL without a new start.
REQ-007 wr_valid  input  1: the pixel source has data on wr_data.
REQ-008 wr_data  input  15: RGB pixel from the source.
REQ-009 wr_ready  output  1: the block accepts wr_data this cycle.
REQ-010 ram_we  output  1: RAM write strobe.
REQ-011 ram_wr_addr  output  20: RAM write address {y[9:0],x[9:0]}.
REQ-012 ram_din  output  15: RAM write data.
REQ-013 ram_re  output  1: RAM read strobe.
REQ-014 ram_rd_addr  output  20: RAM read address {y[9:0],x[9:0]}.
REQ-015 pix_valid  output  1: the RAM read data for (X,Y) is valid this cycle.
REQ-016 X  output  10: column of the pixel currently qualified by pix_valid.
REQ-017 Y  output  10: row of the pixel currently qualified by pix_valid.
REQ-018 busy  output  1: state is not IDLE.
REQ-019 frame_done  output  1: one-cycle pulse when the last pixel of SCAN is qualified.

Function
REQ-020 The FSM SHALL have the states IDLE, FILL, SCAN and DRAIN; ram_we and ram_re SHALL never both be 1 in the same cycle.
- IDLE to FILL on start=1.
- FILL to SCAN after the (H_RES*V_RES)th accepted write.
- SCAN to DRAIN after the last read is issued.
- DRAIN to FILL if loop=1, otherwise to IDLE.
REQ-021 start SHALL be ignored when the state is not IDLE.
REQ-022 wr_ready SHALL be 1 only in FILL; a write is accepted when wr_valid&&wr_ready.
REQ-023 On an accepted write, in the next cycle: ram_we=1, ram_wr_addr={wy,wx}, ram_din=wr_data (registered, 1-cycle latency); otherwise ram_we=0 in that cycle.
REQ-024 Write counters wx/wy SHALL start at 0,0 and advance raster order on each accepted write.
- wx wraps H_RES-1 to 0 and increments wy.
- wy wraps V_RES-1 to 0 on the last pixel.
- Stalls (wr_valid=0) hold both counters.
REQ-025 In SCAN, ram_re SHALL be 1 in every cycle, ram_rd_addr SHALL follow raster order from {0,0} to {V_RES-1,H_RES-1}, and exactly H_RES*V_RES reads SHALL be issued.
REQ-026 The RAM read latency is 1 cycle, so pix_valid, X and Y SHALL equal the previous cycle's ram_re and read coordinates.
- DRAIN lasts exactly 1 cycle, to qualify the final read.
REQ-027 frame_done SHALL pulse in the cycle pix_valid qualifies (V_RES-1,H_RES-1).
REQ-028 When the state enters FILL, from IDLE or via loop, the write counters SHALL be cleared; when it enters SCAN, the read counters SHALL be cleared.
REQ-029 The first SCAN read SHALL occur in the cycle after the last FILL write; there is no overlap.
REQ-030 Addresses for unused bits SHALL be 0: x[9:0] and y[9:0] are zero-extended counter values.

Reset
REQ-031 While rst=0, the block SHALL go to IDLE immediately, independent of clk; all counters and all outputs SHALL be 0, including wr_ready, ram_we, ram_re, ram_wr_addr, ram_rd_addr, ram_din, pix_valid, X, Y, busy and frame_done.
REQ-032 Reset during FILL or SCAN SHALL abandon the frame with no further RAM strobes; after release, the block SHALL stay in IDLE until start.

Verification
REQ-033 H_RES=4, V_RES=2, start, wr_valid=1 with data 0..7 -> ram_we high 8 cycles, addrs {0,0}..{1,3}; then ram_re 8 cycles; frame_done pulses once, on X=3,Y=1.
REQ-034 Same parameters, wr_valid toggled 1/0 -> exactly 8 writes with no address skipped or repeated, and SCAN starts 1 cycle after the last write.
REQ-035 start asserted during SCAN -> no effect; the block returns to IDLE after DRAIN.
REQ-036 loop=1 at DRAIN -> the next cycle is FILL with wr_ready=1, and the write address restarts at {0,0}.
REQ-037 rst=0 pulsed mid-FILL between clock edges -> all outputs 0 before the next edge; after release, busy=0 until start.
REQ-038 H_RES=V_RES=1 -> 1 write, 1 read, and frame_done in the DRAIN cycle.
